sort_result_buffer: RTL

//  Downstream stage of the sort unit. Captures the sorted word stream emitted
//  by the sorter's output phase, holding up to N words in a local register array.

---
 rtl/sort_result_buffer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/sort_result_buffer.sv
// Sort result buffer: captures a sorter frame, replays it over valid/ready.
// Ports: clk/rst, sort_* capture side, m_* consumer side, busy/count/flags.
// Optional macro ORDER_CHECK_EN adds the sort-order checker.
module sort_result_buffer #(
  parameter int N          = 4,
  parameter int W          = 8,
  parameter int DESCENDING = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sort_valid_i,
  input  logic [W-1:0]           sort_data_i,
  input  logic                   sort_done_i,
  output logic                   m_valid_o,
  output logic [W-1:0]           m_data_o,
  output logic                   m_last_o,
  input  logic                   m_ready_i,
  output logic                   busy_o,
  output logic [$clog2(N+1)-1:0] count_o,
  output logic                   overflow_o,
  output logic                   order_err_o
);

  localparam int CW = $clog2(N+1);
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] FULL = CW'(N);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DRAIN
  } state_t;

  state_t        state;
  logic [W-1:0]  mem [N];
  logic [CW-1:0] count;
  logic [AW-1:0] rd_ptr;
  logic          m_valid;
  logic          busy;
  logic          overflow;
  logic          full;
  logic          wr_en;
  logic          xfer;
  logic          last;
  logic [AW-1:0] wr_idx;

  // count doubles as the write pointer; it saturates at N.
  assign full   = (count == FULL);
  assign wr_en  = sort_valid_i &&
                  ((state == IDLE) ||
                   ((state == CAPTURE) && !full));
  assign wr_idx = (state == IDLE) ? '0 : count[AW-1:0];
  assign last   = m_valid &&
                  (CW'(rd_ptr) == count - CW'(1));
  assign xfer   = m_valid && m_ready_i;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= sort_data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      rd_ptr   <= '0;
      m_valid  <= 1'b0;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (sort_valid_i) begin
            count    <= CW'(1);
            overflow <= 1'b0;
            busy     <= 1'b1;
            if (sort_done_i) begin
              state   <= DRAIN;
              m_valid <= 1'b1;
            end else begin
              state <= CAPTURE;
            end
          end
        end
        CAPTURE: begin
          if (sort_valid_i) begin
            if (!full) count <= count + CW'(1);
            else overflow <= 1'b1;
          end
          if (sort_done_i) begin
            state   <= DRAIN;
            m_valid <= 1'b1;
          end
        end
        DRAIN: begin
          if (sort_valid_i) overflow <= 1'b1;
          if (xfer) begin
            if (last) begin
              state   <= IDLE;
              m_valid <= 1'b0;
              busy    <= 1'b0;
              count   <= '0;
              rd_ptr  <= '0;
            end else begin
              rd_ptr <= rd_ptr + AW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ORDER_CHECK_EN
  logic [W-1:0] prev;
  logic         bad;
  logic         order_err;

  // Equal neighbours are legal in either direction.
  assign bad = (DESCENDING != 0) ?
               (sort_data_i > prev) :
               (sort_data_i < prev);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev      <= '0;
      order_err <= 1'b0;
    end else begin
      if (wr_en) prev <= sort_data_i;
      if ((state == IDLE) && sort_valid_i)
        order_err <= 1'b0;
      else if ((state == CAPTURE) && wr_en && bad)
        order_err <= 1'b1;
    end
  end

  assign order_err_o = order_err;
`else
  assign order_err_o = 1'b0;
`endif

  assign m_valid_o  = m_valid;
  assign m_data_o   = mem[rd_ptr];
  assign m_last_o   = last;
  assign busy_o     = busy;
  assign count_o    = count;
  assign overflow_o = overflow;

endmodule
